// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port among NREQ writeback sources.
// Optional counters for arbitration conflicts and stalls when REGFILE_WB_STATS_EN is defined.
module regfile_wb_arbiter #(
   parameter int unsigned NREQ        = 3,
   parameter int unsigned ADR_W       = 5,
   parameter int unsigned DATA_W      = 32,
   parameter bit          ZERO_REG_RO = 1'b0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     stall,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADR_W-1:0]    req_adr,
   input  logic [NREQ*DATA_W-1:0]   req_value,
   output logic [NREQ-1:0]          req_ready,
   output logic                     wenable,
   output logic [ADR_W-1:0]         wadr,
   output logic [DATA_W-1:0]        wvalue,
   output logic [2:0]               grant_id
`ifdef REGFILE_WB_STATS_EN
   ,
   input  logic                     stats_clear,
   output logic [15:0]              conflict_count,
   output logic [15:0]              stall_count
`endif
);

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SUM_W = PTR_W + 1;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  next_ptr;
   logic              gnt_any;
   logic [SUM_W-1:0]  sum;
   logic [ADR_W-1:0]  adr_a [NREQ];
   logic [DATA_W-1:0] val_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign adr_a[i] = req_adr[i*ADR_W +: ADR_W];
      assign val_a[i] = req_value[i*DATA_W +: DATA_W];
   end

   // Scan upward from rr_ptr (mod NREQ); first valid source wins unless stalled or in reset.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      req_ready = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = SUM_W'(rr_ptr) + SUM_W'(k);
         if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
         if (!gnt_any && req_valid[sum[PTR_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = sum[PTR_W-1:0];
         end
      end
      if (stall || !reset_n) gnt_any = 1'b0;
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   assign next_ptr = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

   // Output stage: one registered write per handshake, held fields between grants.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wenable  <= 1'b0;
         wadr     <= '0;
         wvalue   <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         wenable <= 1'b0;
         if (gnt_any) begin
            wadr     <= adr_a[gnt_idx];
            wvalue   <= val_a[gnt_idx];
            grant_id <= 3'(gnt_idx);
            wenable  <= !(ZERO_REG_RO && (adr_a[gnt_idx] == '0));
            rr_ptr   <= next_ptr;
         end
      end
   end

`ifdef REGFILE_WB_STATS_EN
   logic [3:0] nvalid;

   always_comb begin
      nvalid = '0;
      for (int unsigned i = 0; i < NREQ; i++) nvalid = nvalid + 4'(req_valid[i]);
   end

   // Saturating event counters; clear beats increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         conflict_count <= '0;
         stall_count    <= '0;
      end else if (stats_clear) begin
         conflict_count <= '0;
         stall_count    <= '0;
      end else begin
         if (!stall && (nvalid >= 4'd2) && (conflict_count != 16'hFFFF))
            conflict_count <= conflict_count + 16'd1;
         if (stall && (nvalid != 4'd0) && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register bank between NREQ writeback sources: ALU, load unit and multiplier by default.
- Round-robin grant with a valid/ready handshake per source.
- Registered output stage drives the bank's wenable/wadr/wvalue.
- Sits between the execute/memory stages and the register bank.
- A write presented in cycle t is committed by the bank on the falling edge inside cycle t+1.

Parameters:
- NREQ, 3: number of writeback requesters (2..8).
- ADR_W, 5: register address width.
- DATA_W, 32: register data width.
- ZERO_REG_RO, 0: when 1, writes to address 0 are accepted (handshake completes) but wenable stays 0.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  when 1, no grant is issued this cycle.
- req_valid  in  NREQ  per-source write request.
- req_adr  in  NREQ*ADR_W  source i address in bits i*ADR_W .. i*ADR_W+ADR_W-1.
- req_value  in  NREQ*DATA_W  source i data in bits i*DATA_W .. i*DATA_W+DATA_W-1.
- req_ready  out  NREQ  one-hot grant; the transfer completes when valid&ready.
- wenable  out  1  bank write enable, registered.
- wadr  out  ADR_W  bank write address, registered.
- wvalue  out  DATA_W  bank write data, registered.
- grant_id  out  3  index of the source whose write is currently on wenable, registered.

Behaviour:
- Reset is asynchronous on reset_n low:
  - wenable=0, wadr=0, wvalue=0, grant_id=0, rr_ptr=0.
  - req_ready is forced to 0 while reset_n=0.
- req_ready is combinational from req_valid, rr_ptr and stall:
  - Scan from index rr_ptr upward, modulo NREQ.
  - The first source with valid=1 gets ready=1; all others get 0.
  - stall=1 or no valid source gives ready=0 for all sources.
  - There is never more than one ready bit set.
- Rising edge with a grant to source g:
  - wadr and wvalue take source g's slice; grant_id=g.
  - wenable=1, except wenable=0 when ZERO_REG_RO=1 and adr=0.
  - rr_ptr=(g+1) mod NREQ.
- Rising edge with no grant: wenable=0; wadr, wvalue, grant_id and rr_ptr hold.
- Latency is exactly 1 cycle from handshake to wenable.
- wenable is high for exactly one cycle per accepted write.
- Back-to-back grants sustain 1 write per cycle.
- Sources must hold valid, adr and value stable until ready. The arbiter does not buffer un-granted requests.
- Same-address requests from two sources in the same cycle are serialized in round-robin order, so the later grant overwrites the earlier one in the bank.
- Starvation bound: a continuously valid source is granted within NREQ cycles of non-stall operation.
- Asserting stall mid-stream:
  - The write already registered still appears on wenable in that cycle.
  - No new grant is issued; rr_ptr holds.
- Reset asserted mid-stream:
  - Any registered write is dropped immediately and wenable goes to 0 asynchronously.
  - An in-progress handshake in that cycle does not complete.
- A valid source with index >= NREQ cannot exist; widths are derived from NREQ.

Optional Feature:
- Macro: REGFILE_WB_STATS_EN.
- When defined, these ports and logic are added:
  - conflict_count  out  16: counts cycles with >=2 valid sources and stall=0; saturates at 16'hFFFF; reset to 0.
  - stall_count  out  16: counts cycles with stall=1 and >=1 valid source; saturates; reset to 0.
  - stats_clear  in  1: synchronous clear of both counters; takes priority over increment.
- When undefined, none of these ports or registers exist, and arbitration behaviour is identical.

Test Plan:
- Reset check: reset_n=0 with all valids=1 -> wenable=0, req_ready=000, wadr=0. Release reset -> the first grant goes to source 0.
- Single source: source 1 valid, adr=7, value=32'hDEADBEEF for one cycle -> req_ready=010 that cycle. Next cycle wenable=1, wadr=7, wvalue=32'hDEADBEEF, grant_id=1. The cycle after, wenable=0.
- Round-robin: all 3 sources valid continuously, addresses 1/2/3 -> grants in order 0,1,2,0,1,2 on consecutive cycles, with wadr sequence 1,2,3,1,2,3 lagging by one cycle.
- Same-address conflict: sources 0 and 2 both write adr=4 (values 32'h11 and 32'h22), rr_ptr=2 -> source 2 is granted first, then source 0. A read of register 4 after both writes returns 32'h11.
- Stall: stall=1 for 3 cycles with source 0 valid -> req_ready=0 and wenable=0 for those cycles, rr_ptr unchanged. Drop stall -> source 0 is granted in that cycle.
- Zero register, with ZERO_REG_RO=1: source 0 writes adr=0 -> ready=1 and the handshake completes, but wenable stays 0 the next cycle. Under REGFILE_WB_STATS_EN, 5 cycles with 2 valid sources -> conflict_count=5; then stats_clear -> 0.
